// File: rtl/path_count_engine.sv
// -----------------------------------------------------------------------------
// path_count_engine
//
// Counts distinct src->dst paths in a DAG using Kahn-order propagation.
// The host preloads per-node in-degrees (which also marks a node as present),
// then pulses start_run. The engine seeds a worklist with every present
// zero-in-degree node, pops nodes one at a time, fetches each node's successor
// list over the adjacency request/response stream, and pushes path counts
// forward, saturating at the counter maximum.
//
// Optional build macro: PATH_WAYPOINT_EN
//   Adds wp_a_idx / wp_b_idx. Each node keeps four counters indexed by the
//   waypoint-visited mask {b,a}, and the answer is the count of paths that
//   pass through both waypoints.
//
// Ports
//   clk, rst          clock, synchronous active-high reset
//   start_run         start pulse (IDLE only); latches src_idx / dst_idx
//   ld_en/ld_idx/ld_indeg  in-degree preload (IDLE only), sets node valid
//   adj_req_*         adjacency request for the node being expanded
//   adj_rsp_*         successor beats; adj_rsp_none marks an empty list
//   busy              high outside IDLE
//   done_reg          result valid until next start_run or rst
//   part1_ans         registered path count, updated only at end of run
//   sat_flag          some accumulation saturated
//   err_flag          worklist overflow or in-degree underflow
// -----------------------------------------------------------------------------
module path_count_engine #(
    parameter int NODE_IDX_WIDTH  = 10,
    parameter int COUNTER_WIDTH   = 4,
    parameter int ACCUM_VAL_WIDTH = 24,
    parameter int FIFO_DEPTH      = 32
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start_run,
    input  logic [NODE_IDX_WIDTH-1:0]  src_idx,
    input  logic [NODE_IDX_WIDTH-1:0]  dst_idx,
    input  logic                       ld_en,
    input  logic [NODE_IDX_WIDTH-1:0]  ld_idx,
    input  logic [COUNTER_WIDTH-1:0]   ld_indeg,
`ifdef PATH_WAYPOINT_EN
    input  logic [NODE_IDX_WIDTH-1:0]  wp_a_idx,
    input  logic [NODE_IDX_WIDTH-1:0]  wp_b_idx,
`endif
    output logic                       adj_req_valid,
    output logic [NODE_IDX_WIDTH-1:0]  adj_req_idx,
    input  logic                       adj_req_ready,
    input  logic                       adj_rsp_valid,
    input  logic [NODE_IDX_WIDTH-1:0]  adj_rsp_idx,
    input  logic                       adj_rsp_none,
    input  logic                       adj_rsp_last,
    output logic                       busy,
    output logic                       done_reg,
    output logic [ACCUM_VAL_WIDTH-1:0] part1_ans,
    output logic                       sat_flag,
    output logic                       err_flag
);
    localparam int NIW     = NODE_IDX_WIDTH;
    localparam int CW      = COUNTER_WIDTH;
    localparam int AW      = ACCUM_VAL_WIDTH;
    localparam int NODES   = 1 << NIW;
    localparam int FIFO_AW = $clog2(FIFO_DEPTH);
    localparam int PTR_W   = FIFO_AW + 1;
`ifdef PATH_WAYPOINT_EN
    localparam int LANES   = 4;
`else
    localparam int LANES   = 1;
`endif
    // Headroom of 3 bits covers the worst case of five addends into one lane.
    localparam logic [AW+2:0] ACC_MAX = {3'b000, {AW{1'b1}}};

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_SEED = 3'd1;
    localparam logic [2:0] S_POP  = 3'd2;
    localparam logic [2:0] S_REQ  = 3'd3;
    localparam logic [2:0] S_WALK = 3'd4;
    localparam logic [2:0] S_FIN  = 3'd5;

    logic [2:0]       state_reg, state_next;
    logic [NIW-1:0]   src_reg, dst_reg, cur_reg, scan_reg;
    logic [PTR_W-1:0] wr_ptr_reg, rd_ptr_reg;
    logic [NIW-1:0]   fifo_mem [FIFO_DEPTH];

    // Flattened views of the per-node storage for combinational reads.
    logic [CW-1:0]    indeg_vec [NODES];
    logic             valid_vec [NODES];
    logic [AW-1:0]    count_vec [NODES][LANES];

    logic [1:0]       src_mask, succ_mask;
    logic [AW-1:0]    walk_next [LANES];
    logic             walk_sat;

`ifdef PATH_WAYPOINT_EN
    logic [NIW-1:0]   wp_a_reg, wp_b_reg;
    assign src_mask  = {src_reg == wp_b_reg, src_reg == wp_a_reg};
    assign succ_mask = {adj_rsp_idx == wp_b_reg, adj_rsp_idx == wp_a_reg};
`else
    assign src_mask  = 2'b00;
    assign succ_mask = 2'b00;
`endif

    // ------------------------------------------------------------------
    // Per-cycle control strobes
    // ------------------------------------------------------------------
    logic          clear_all, ld_we, seed_we;
    logic          beat_apply, dec_we, underflow;
    logic          seed_push, walk_push, push_req, push_ok, overflow, pop_en;
    logic          fifo_full, fifo_empty;
    logic [CW-1:0] succ_indeg;
    logic [NIW-1:0] push_idx;

    assign clear_all  = (state_reg == S_IDLE) && start_run;
    assign ld_we      = (state_reg == S_IDLE) && ld_en;
    assign seed_we    = (state_reg == S_SEED) && (scan_reg == '0);

    assign beat_apply = (state_reg == S_WALK) && adj_rsp_valid && !adj_rsp_none;
    assign succ_indeg = indeg_vec[adj_rsp_idx];
    assign dec_we     = beat_apply && (succ_indeg != '0);
    assign underflow  = beat_apply && (succ_indeg == '0);

    assign seed_push  = (state_reg == S_SEED) && valid_vec[scan_reg] && (indeg_vec[scan_reg] == '0);
    // A successor becomes ready when this beat takes its in-degree from 1 to 0.
    assign walk_push  = dec_we && (succ_indeg == CW'(1));
    assign push_req   = seed_push || walk_push;
    assign push_idx   = seed_push ? scan_reg : adj_rsp_idx;

    assign fifo_empty = (wr_ptr_reg == rd_ptr_reg);
    assign fifo_full  = ((wr_ptr_reg - rd_ptr_reg) == PTR_W'(FIFO_DEPTH));
    assign push_ok    = push_req && !fifo_full;
    assign overflow   = push_req && fifo_full;
    assign pop_en     = (state_reg == S_POP) && !fifo_empty;

    assign busy          = (state_reg != S_IDLE);
    assign adj_req_valid = (state_reg == S_REQ);
    assign adj_req_idx   = cur_reg;

    // ------------------------------------------------------------------
    // Saturating propagation: lane m of cur lands in lane (m | mask(s)).
    // Several source lanes may fold into the same destination lane.
    // ------------------------------------------------------------------
    always_comb begin
        logic [AW+2:0] acc;
        acc      = '0;
        walk_sat = 1'b0;
        for (int t = 0; t < LANES; t++) begin
            acc = {3'b000, count_vec[adj_rsp_idx][t]};
            for (int m = 0; m < LANES; m++) begin
                if ((2'(m) | succ_mask) == 2'(t)) begin
                    acc = acc + {3'b000, count_vec[cur_reg][m]};
                end
            end
            if (acc > ACC_MAX) begin
                walk_next[t] = {AW{1'b1}};
                walk_sat     = 1'b1;
            end else begin
                walk_next[t] = acc[AW-1:0];
            end
        end
    end

    // ------------------------------------------------------------------
    // Per-node storage: in-degree, valid bit, path counters
    // ------------------------------------------------------------------
    for (genvar gi = 0; gi < NODES; gi++) begin : g_node
        logic [CW-1:0] indeg_reg;
        logic          valid_reg;
        logic [AW-1:0] count_reg [LANES];

        always_ff @(posedge clk) begin
            if (rst) begin
                indeg_reg <= '0;
                valid_reg <= 1'b0;
                for (int l = 0; l < LANES; l++) begin
                    count_reg[l] <= '0;
                end
            end else begin
                if (ld_we && (ld_idx == NIW'(gi))) begin
                    indeg_reg <= ld_indeg;
                    valid_reg <= 1'b1;
                end else if (dec_we && (adj_rsp_idx == NIW'(gi))) begin
                    indeg_reg <= indeg_reg - 1'b1;
                end

                if (clear_all) begin
                    for (int l = 0; l < LANES; l++) begin
                        count_reg[l] <= '0;
                    end
                end else if (seed_we && (src_reg == NIW'(gi))) begin
                    for (int l = 0; l < LANES; l++) begin
                        count_reg[l] <= (2'(l) == src_mask) ? AW'(1) : '0;
                    end
                end else if (beat_apply && (adj_rsp_idx == NIW'(gi))) begin
                    for (int l = 0; l < LANES; l++) begin
                        count_reg[l] <= walk_next[l];
                    end
                end
            end
        end

        assign indeg_vec[gi] = indeg_reg;
        assign valid_vec[gi] = valid_reg;
        for (genvar li = 0; li < LANES; li++) begin : g_lane
            assign count_vec[gi][li] = count_reg[li];
        end
    end

    // ------------------------------------------------------------------
    // FSM next state
    // ------------------------------------------------------------------
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_IDLE: if (start_run) state_next = S_SEED;
            S_SEED: if (scan_reg == {NIW{1'b1}}) state_next = S_POP;
            S_POP:  state_next = fifo_empty ? S_FIN : S_REQ;
            S_REQ:  if (adj_req_ready) state_next = S_WALK;
            S_WALK: if (adj_rsp_valid && adj_rsp_last) state_next = S_POP;
            S_FIN:  state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    // Worklist storage needs no reset; the pointers define its contents.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            fifo_mem[wr_ptr_reg[FIFO_AW-1:0]] <= push_idx;
        end
    end

    // ------------------------------------------------------------------
    // Control registers and result
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg  <= S_IDLE;
            src_reg    <= '0;
            dst_reg    <= '0;
            cur_reg    <= '0;
            scan_reg   <= '0;
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            done_reg   <= 1'b0;
            part1_ans  <= '0;
            sat_flag   <= 1'b0;
            err_flag   <= 1'b0;
`ifdef PATH_WAYPOINT_EN
            wp_a_reg   <= '0;
            wp_b_reg   <= '0;
`endif
        end else begin
            state_reg <= state_next;
            case (state_reg)
                S_IDLE: begin
                    if (start_run) begin
                        src_reg    <= src_idx;
                        dst_reg    <= dst_idx;
                        scan_reg   <= '0;
                        wr_ptr_reg <= '0;
                        rd_ptr_reg <= '0;
                        done_reg   <= 1'b0;
                        sat_flag   <= 1'b0;
                        err_flag   <= 1'b0;
`ifdef PATH_WAYPOINT_EN
                        wp_a_reg   <= wp_a_idx;
                        wp_b_reg   <= wp_b_idx;
`endif
                    end
                end
                S_SEED: scan_reg <= scan_reg + 1'b1;
                S_FIN: begin
                    part1_ans <= count_vec[dst_reg][LANES-1];
                    done_reg  <= 1'b1;
                end
                default: ;
            endcase

            if (pop_en) begin
                cur_reg    <= fifo_mem[rd_ptr_reg[FIFO_AW-1:0]];
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
            if (push_ok) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (overflow || underflow) begin
                err_flag <= 1'b1;
            end
            if (beat_apply && walk_sat) begin
                sat_flag <= 1'b1;
            end
        end
    end

endmodule

// File: doc/path_count_engine.md
Name: path_count_engine

Overview:
- Parametrised successor to the fixed-width node walker in digital_top.
- Counts distinct paths from a source node to a destination node in a DAG, using Kahn-order propagation.
- Adjacency lists come from an external memory through a request/response stream; per-node in-degree is preloaded by the host.
- Holds per-node path counts, in-degree counters and a zero-in-degree worklist FIFO internally.

Parameters:
- NODE_IDX_WIDTH, 10, node index width; the node table has 2^NODE_IDX_WIDTH entries.
- COUNTER_WIDTH, 4, in-degree counter width.
- ACCUM_VAL_WIDTH, 24, path-count width (saturating).
- FIFO_DEPTH, 32, worklist entries; must be a power of two and at least 2.

Ports:
- clk  in  1  clock
- rst  in  1  reset
- start_run  in  1  one-cycle start pulse; honoured only in IDLE
- src_idx  in  NODE_IDX_WIDTH  source node; sampled at start_run
- dst_idx  in  NODE_IDX_WIDTH  destination node; sampled at start_run
- ld_en  in  1  in-degree load strobe; honoured only in IDLE
- ld_idx  in  NODE_IDX_WIDTH  node being loaded
- ld_indeg  in  COUNTER_WIDTH  in-degree value; the write also sets the node's valid bit
- adj_req_valid  out  1  adjacency request for one node
- adj_req_idx  out  NODE_IDX_WIDTH  node whose list is requested
- adj_req_ready  in  1  request accepted when valid and ready are both high
- adj_rsp_valid  in  1  one successor beat
- adj_rsp_idx  in  NODE_IDX_WIDTH  successor index
- adj_rsp_none  in  1  node has no successors; adj_rsp_idx is ignored
- adj_rsp_last  in  1  final beat of the list
- busy  out  1  high in every state except IDLE
- done_reg  out  1  result valid; held until the next start_run or rst
- part1_ans  out  ACCUM_VAL_WIDTH  path count src→dst
- sat_flag  out  1  at least one accumulation saturated
- err_flag  out  1  FIFO overflow or in-degree underflow

Behaviour:
- One clock. Reset is synchronous and active-high.
- On rst, all outputs are 0, state is IDLE, and every valid bit, count, in-degree and FIFO pointer is cleared. rst mid-run aborts immediately; no partial result is reported.
- States: IDLE → SEED → POP → REQ → WALK → POP ... → FIN → IDLE.
- IDLE:
  - ld_en writes indeg[ld_idx] and sets valid[ld_idx].
  - start_run latches src_idx/dst_idx, clears done_reg, sat_flag, err_flag and all counts, then goes to SEED.
  - start_run in any other state is ignored.
- SEED:
  - Scans index 0..2^NODE_IDX_WIDTH-1, one per cycle. Each valid node with indeg==0 is pushed to the FIFO.
  - count[src] is set to 1 in the first SEED cycle.
  - After the last index, go to POP.
- POP:
  - FIFO empty: go to FIN.
  - Otherwise pop to cur and go to REQ.
- REQ: drive adj_req_valid=1, adj_req_idx=cur. Hold until ready, then go to WALK. Requests never overlap.
- WALK, one beat per cycle when adj_rsp_valid is high:
  - The beat applies to successor s = adj_rsp_idx.
  - count[s] is updated to count[s]+count[cur], saturating at 2^ACCUM_VAL_WIDTH-1; saturation sets sat_flag.
  - indeg[s] decrements. If it reaches 0, s is pushed.
  - indeg[s]==0 before the decrement: set err_flag and do not push.
  - adj_rsp_none skips the update.
  - The last beat returns to POP.
  - A push into a full FIFO is dropped and sets err_flag.
- FIN: part1_ans=count[dst], done_reg=1, go to IDLE. part1_ans is registered and changes only in FIN or on rst.
- Runs stay deterministic after an error: the walk finishes and the result is reported with err_flag set.
- Unvisited dst, or src==dst with no in-edges: the answer is count[dst] as stored (0 or 1 respectively).
- count[] and indeg[] are register arrays with combinational read and one write per cycle.
- Loaded in-degrees are consumed by a run. The host must reload them before the next start_run.

Optional Feature:
- Macro PATH_WAYPOINT_EN.
- Defined:
  - Adds inputs wp_a_idx and wp_b_idx (NODE_IDX_WIDTH each), sampled at start_run.
  - count becomes four counters per node, indexed by a visited mask {b,a}.
  - count[src][mask(src)]=1 at seed.
  - WALK adds count[cur][m] into count[s][m | mask(s)] for all four m in one cycle.
  - FIN reports count[dst][2'b11], i.e. paths through both waypoints.
- Undefined: no wp ports, single counter per node, behaviour as above.

Test Plan:
- Diamond 0→1, 0→2, 1→3, 2→3; src=0, dst=3 → part1_ans=2, done_reg=1, flags 0.
- Chain 0→1→2 with node 5 isolated (valid, no successors, adj_rsp_none); src=0, dst=2 → part1_ans=1. Node 5 is popped once and its response is accepted.
- ACCUM_VAL_WIDTH=4, five cascaded diamonds (32 paths) → part1_ans=15, sat_flag=1.
- FIFO_DEPTH=2, four valid nodes with indeg 0 → err_flag=1; done_reg still asserts.
- rst asserted during WALK, then reload and rerun the diamond → busy drops the next cycle, outputs read 0, rerun gives 2.
- PATH_WAYPOINT_EN: 0→1, 0→2, 1→2, 2→3, 1→3; wp_a=1, wp_b=2, src=0, dst=3 → part1_ans=1 (path 0-1-2-3).
